// File: rtl/cond_decoder.sv
// Condition-code evaluator with a one-entry valid/ready output register
// and a saturating counter of taken results.
module cond_decoder #(
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            V,
   input  logic            N,
   input  logic            Z,
   input  logic [3:0]      cond,
   input  logic            clr_cnt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            taken,
   output logic            cond_err,
   output logic [CNTW-1:0] taken_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            r_state_p1;
   logic              r_taken_p1;
   logic              r_err_p1;
   logic [CNTW-1:0]   r_cnt_p1;
   logic              w_accept;
   logic [1:0]        w_res_p0;

   // Result packed as {cond_err, taken}; reserved codes never report taken.
   function automatic logic [1:0] eval_cond(input logic [3:0] c, input logic v,
                                            input logic n, input logic z);
      logic lt;
      logic [1:0] res;
      lt  = n ^ v;
      res = 2'b10;
      case (c)
         4'd0:    res = {1'b0, z};
         4'd1:    res = {1'b0, ~z};
         4'd2:    res = {1'b0, n};
         4'd3:    res = {1'b0, ~n};
         4'd4:    res = {1'b0, v};
         4'd5:    res = {1'b0, ~v};
         4'd6:    res = {1'b0, lt};
         4'd7:    res = {1'b0, ~lt};
         4'd8:    res = {1'b0, ~z & ~lt};
         4'd9:    res = {1'b0, z | lt};
         4'd10:   res = 2'b01;
         4'd11:   res = 2'b00;
         default: res = 2'b10;
      endcase
      return res;
   endfunction

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign out_valid = (r_state_p1 == FULL);
   assign in_ready  = ~out_valid | out_ready;
   assign w_accept  = in_valid & in_ready;
   assign w_res_p0  = eval_cond(cond, V, N, Z);
   assign taken     = r_taken_p1;
   assign cond_err  = r_err_p1;
   assign taken_cnt = r_cnt_p1;

   // Stage p0 -> p1: evaluate on acceptance, hold while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_p1 <= EMPTY;
         r_taken_p1 <= 1'b0;
         r_err_p1   <= 1'b0;
         r_cnt_p1   <= '0;
      end else begin
         case (r_state_p1)
            EMPTY:   if (w_accept) r_state_p1 <= FULL;
            FULL:    if (out_ready && !w_accept) r_state_p1 <= EMPTY;
            default: r_state_p1 <= EMPTY;
         endcase
         if (w_accept) begin
            r_taken_p1 <= w_res_p0[0];
            r_err_p1   <= w_res_p0[1];
         end
         if (clr_cnt)
            r_cnt_p1 <= '0;
         else if (w_accept && w_res_p0 == 2'b01)
            r_cnt_p1 <= sat_inc(r_cnt_p1);
      end
   end

endmodule

// File: tb/tb_cond_decoder.sv
// Randomized and directed bench for cond_decoder against a flag-level
// reference model of the condition table, handshake and counter.
module tb_cond_decoder;

   localparam int CNTW = 2;
   localparam int MAXC = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready;
   logic V = 1'b0, N = 1'b0, Z = 1'b0;
   logic [3:0] cond = 4'd0;
   logic clr_cnt = 1'b0;
   logic out_valid, out_ready = 1'b0;
   logic taken, cond_err;
   logic [CNTW-1:0] taken_cnt;

   int n_checks = 0;
   int n_pass = 0;

   // Reference model state
   bit m_ov = 0, m_taken = 0, m_err = 0;
   int m_cnt = 0;

   cond_decoder #(.CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .V(V), .N(N), .Z(Z), .cond(cond), .clr_cnt(clr_cnt),
      .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
      .cond_err(cond_err), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   // Flags of a 4-bit X-Y subtraction from true integer arithmetic.
   task automatic set_flags_xy(input int x, input int y);
      int d, r;
      d = x - y;
      r = d & 15;
      N = (r >= 8);
      Z = (r == 0);
      V = (d < -8) || (d > 7);
   endtask

   // Condition meaning in terms of the comparison it stands for.
   function automatic void ref_eval(input int c, input bit n, input bit v, input bit z,
                                    output bit t, output bit e);
      bit less;
      less = (n != v);
      e = (c >= 12);
      t = 0;
      if      (c == 0)  t = z;
      else if (c == 1)  t = !z;
      else if (c == 2)  t = n;
      else if (c == 3)  t = !n;
      else if (c == 4)  t = v;
      else if (c == 5)  t = !v;
      else if (c == 6)  t = less;
      else if (c == 7)  t = !less;
      else if (c == 8)  t = !less && !z;
      else if (c == 9)  t = less || z;
      else if (c == 10) t = 1;
   endfunction

   task automatic cycle();
      bit acc, t, e;
      acc = in_valid && (!m_ov || out_ready);
      ref_eval(int'(cond), N, V, Z, t, e);
      @(posedge clk); #1;
      if (acc) begin m_taken = t; m_err = e; m_ov = 1; end
      else if (out_ready) m_ov = 0;
      if (clr_cnt) m_cnt = 0;
      else if (acc && t && !e) m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
   endtask

   task automatic model_reset();
      m_ov = 0; m_taken = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (taken !== 1'b0) $display("FAIL rst_taken got=%b exp=0", taken); else n_pass++;
      n_checks++; if (cond_err !== 1'b0) $display("FAIL rst_cond_err got=%b exp=0", cond_err); else n_pass++;
      n_checks++; if (taken_cnt !== 2'd0) $display("FAIL rst_cnt got=%0d exp=0", taken_cnt); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); else n_pass++;
   endtask

   task automatic test_lt_gt();
      out_ready = 1'b1; in_valid = 1'b1;
      set_flags_xy(3, 5); cond = 4'd6;
      cycle();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL lt_valid got=%b exp=1", out_valid); else n_pass++;
      n_checks++; if (taken !== 1'b1) $display("FAIL lt_taken got=%b exp=1", taken); else n_pass++;
      cond = 4'd8;
      cycle();
      n_checks++; if (taken !== 1'b0 || out_valid !== 1'b1) $display("FAIL gt_taken got=%b/%b exp=0/1", taken, out_valid); else n_pass++;
      n_checks++; if (taken_cnt !== 2'd1) $display("FAIL lt_gt_cnt got=%0d exp=1", taken_cnt); else n_pass++;
      in_valid = 1'b0;
      cycle();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", out_valid); else n_pass++;
   endtask

   task automatic test_ge_overflow();
      out_ready = 1'b1; in_valid = 1'b1;
      set_flags_xy(7, -1); cond = 4'd7;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (taken !== 1'b1 || cond_err !== 1'b0) $display("FAIL ge_ovf got=%b/%b exp=1/0", taken, cond_err); else n_pass++;
      cycle();
   endtask

   task automatic test_backpressure();
      logic t0, e0;
      logic [CNTW-1:0] c0;
      clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1;
      set_flags_xy(2, 2); cond = 4'd0;
      cycle();
      t0 = taken; e0 = cond_err; c0 = taken_cnt;
      n_checks++; if (t0 !== 1'b1 || c0 !== 2'd1) $display("FAIL bp_load got=%b/%0d exp=1/1", t0, c0); else n_pass++;
      cond = 4'd10;
      for (int i = 0; i < 3; i++) begin
         {N, V, Z} = 3'($urandom);
         n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else n_pass++;
         cycle();
         n_checks++; if (taken !== t0 || cond_err !== e0 || out_valid !== 1'b1) $display("FAIL bp_hold cyc=%0d got=%b/%b/%b exp=%b/%b/1", i, taken, cond_err, out_valid, t0, e0); else n_pass++;
         n_checks++; if (taken_cnt !== c0) $display("FAIL bp_cnt cyc=%0d got=%0d exp=%0d", i, taken_cnt, c0); else n_pass++;
      end
      cond = 4'd1; Z = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else n_pass++;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || taken_cnt !== 2'd2) $display("FAIL bp_no_bubble got=%b/%b/%0d exp=1/1/2", out_valid, taken, taken_cnt); else n_pass++;
      cycle();
   endtask

   task automatic test_reserved();
      logic [CNTW-1:0] c0;
      c0 = taken_cnt;
      out_ready = 1'b1; in_valid = 1'b1;
      {N, V, Z} = 3'($urandom); cond = 4'd13;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (taken !== 1'b0 || cond_err !== 1'b1) $display("FAIL reserved got=%b/%b exp=0/1", taken, cond_err); else n_pass++;
      n_checks++; if (taken_cnt !== c0) $display("FAIL reserved_cnt got=%0d exp=%0d", taken_cnt, c0); else n_pass++;
      cycle();
   endtask

   task automatic test_saturate();
      int exp_seq[5] = '{1, 2, 3, 3, 3};
      clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; cond = 4'd10;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_checks++; if (int'(taken_cnt) !== exp_seq[i]) $display("FAIL sat_cnt idx=%0d got=%0d exp=%0d", i, taken_cnt, exp_seq[i]); else n_pass++;
      end
      clr_cnt = 1'b1;
      cycle();
      clr_cnt = 1'b0; in_valid = 1'b0;
      n_checks++; if (taken_cnt !== 2'd0) $display("FAIL clr_priority got=%0d exp=0", taken_cnt); else n_pass++;
      cycle();
   endtask

   task automatic test_random();
      bit exp_rdy;
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr_cnt   = ($urandom_range(0, 15) == 0);
         {N, V, Z} = 3'($urandom);
         cond      = 4'($urandom);
         #1;
         exp_rdy = !m_ov || out_ready;
         n_checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_in_ready i=%0d got=%b exp=%b", i, in_ready, exp_rdy); else n_pass++;
         cycle();
         n_checks++; if (out_valid !== m_ov || taken !== m_taken || cond_err !== m_err) $display("FAIL rnd_out i=%0d got=%b/%b/%b exp=%b/%b/%b", i, out_valid, taken, cond_err, m_ov, m_taken, m_err); else n_pass++;
         n_checks++; if (int'(taken_cnt) !== m_cnt) $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, taken_cnt, m_cnt); else n_pass++;
      end
      in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1; cond = 4'd10;
      cycle();
      n_checks++; if (out_valid !== 1'b1 || taken_cnt === 2'd0) $display("FAIL ar_setup got=%b/%0d exp=1/nonzero", out_valid, taken_cnt); else n_pass++;
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (out_valid !== 1'b0 || taken_cnt !== 2'd0 || taken !== 1'b0) $display("FAIL ar_immediate got=%b/%0d/%b exp=0/0/0", out_valid, taken_cnt, taken); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready got=%b exp=1", in_ready); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_stale got=%b exp=0", out_valid); else n_pass++;
      out_ready = 1'b1; in_valid = 1'b1; cond = 4'd11;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || taken !== 1'b0 || taken_cnt !== 2'd0) $display("FAIL ar_first_accept got=%b/%b/%0d exp=1/0/0", out_valid, taken, taken_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_lt_gt();
      test_ge_overflow();
      test_backpressure();
      test_reserved();
      test_saturate();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cond_decoder.md
COND_DECODER -- requirements
Module: cond_decoder

Interface
REQ-001 The module SHALL have one parameter: CNTW, default 8, meaning the width of the taken-result counter.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: a flag set and condition are presented.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block can accept an input this cycle.
REQ-006 The module SHALL have ports V, N, Z, input, 1 bit each: overflow, negative and zero flags of an X-Y subtraction.
REQ-007 The module SHALL have port cond, input, 4 bits: the condition code to evaluate.
REQ-008 The module SHALL have port clr_cnt, input, 1 bit: synchronous clear of taken_cnt.
REQ-009 The module SHALL have port out_valid, output, 1 bit: a result is held in the output register.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream block accepts the result.
REQ-011 The module SHALL have port taken, output, 1 bit: the evaluated condition result.
REQ-012 The module SHALL have port cond_err, output, 1 bit: the held result came from a reserved code.
REQ-013 The module SHALL have port taken_cnt, output, CNTW bits: a saturating count of accepted taken results.

Function
REQ-014 The condition table SHALL be: 0 EQ=Z; 1 NE=~Z; 2 MI=N; 3 PL=~N; 4 VS=V; 5 VC=~V; 6 LT=N^V; 7 GE=~(N^V); 8 GT=~Z&~(N^V); 9 LE=Z|(N^V); 10 AL=1; 11 NV=0.
REQ-015 Codes 12-15 SHALL be treated as reserved: taken=0 and cond_err=1. Codes 0-11 SHALL give cond_err=0.
REQ-016 An input SHALL be accepted exactly on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be a combinational function: in_ready = ~out_valid | out_ready.
REQ-018 On acceptance, taken and cond_err SHALL be loaded into the output register, and out_valid SHALL be 1 from the next cycle on. Latency SHALL be exactly 1 cycle.
REQ-019 While out_valid=1 and out_ready=0, taken, cond_err and out_valid SHALL hold their values, and no input SHALL be accepted.
REQ-020 When out_valid=1, out_ready=1 and a new input is accepted on the same edge, the output register SHALL load the new result and out_valid SHALL stay 1. There SHALL be no bubble.
REQ-021 When out_valid=1, out_ready=1 and no input is accepted, out_valid SHALL go to 0 on that edge.
REQ-022 The block SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1). Transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; otherwise hold.
REQ-023 taken_cnt SHALL increment by 1 on each acceptance whose result is taken=1 and cond_err=0.
REQ-024 taken_cnt SHALL saturate at 2^CNTW-1 and SHALL NOT wrap.
REQ-025 When clr_cnt=1, taken_cnt SHALL become 0 on the next edge. This SHALL take priority over a simultaneous increment, and that increment SHALL be dropped.
REQ-026 Flag inputs and cond SHALL be sampled only on acceptance. Their values at any other time SHALL have no effect.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force out_valid=0, taken=0, cond_err=0 and taken_cnt=0.
REQ-028 in_ready SHALL be 1 during reset and on the first cycle after reset.
REQ-029 Assertion of reset while FULL SHALL discard the held result. No stale output SHALL appear after rst_n deasserts.
REQ-030 Release of rst_n SHALL be synchronous to clk. The first acceptance SHALL be possible on the first rising edge after release.

Verification
REQ-031 The bench SHALL apply flags of X=3,Y=5 (N=1,V=0,Z=0) with cond=6 (LT), then with cond=8 (GT). The required response is taken=1 then taken=0, each with out_valid one cycle after acceptance, and taken_cnt=1.
REQ-032 The bench SHALL apply flags of 4-bit X=7,Y=-1 (N=1,V=1,Z=0) with cond=7 (GE). The required response is taken=1 and cond_err=0.
REQ-033 The bench SHALL hold out_ready=0 for 3 cycles while FULL with in_valid=1. The required response is in_ready=0, stable taken and cond_err, and no taken_cnt change. On out_ready=1 the pending input SHALL be accepted with no bubble.
REQ-034 The bench SHALL apply cond=13 with any flags. The required response is taken=0, cond_err=1 and taken_cnt unchanged.
REQ-035 The bench SHALL use CNTW=2 and send 5 accepted AL inputs. The required response is taken_cnt 1,2,3,3,3. Then clr_cnt=1 together with an AL acceptance SHALL give taken_cnt=0.
REQ-036 The bench SHALL pulse rst_n low mid-cycle while FULL. The required response is immediate out_valid=0 and taken_cnt=0, and in_ready=1 before the next clk edge.
